// File: rtl/odo_pkg.sv
// Shared types and constants for the Keccak nonce scanner: FSM encoding,
// header geometry and a small popcount helper.
package odo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

  localparam int HEADER_W  = 640;
  localparam int NONCE_MSB = 639;
  localparam int NONCE_LSB = 608;
  localparam int NONCE_W   = NONCE_MSB - NONCE_LSB + 1;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/odo_nonce_fifo.sv
// Found-nonce FIFO: a push that finds the FIFO full is dropped and flagged,
// unless a pop frees a slot in the same cycle.
module odo_nonce_fifo
  import odo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = NONCE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             not_empty,
  output logic             drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full, do_push, do_pop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    full    = (cnt_q == CW'(DEPTH));
    do_pop  = pop && (cnt_q != '0);
    do_push = push_valid && (!full || do_pop);
    drop    = push_valid && !do_push;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d        = bump(wr_q);
    end
    if (do_pop) rd_d = bump(rd_q);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head      = mem_q[rd_q];
  assign not_empty = (cnt_q != '0);

endmodule

// File: rtl/odo_keccak_scan.sv
// Nonce-range scanner feeding an external fixed-latency hash core.
// Optional feature macro: ODO_SCAN_STATS_EN adds the 48-bit hash_count output.
module odo_keccak_scan
  import odo_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int PIPE_DEPTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [HEADER_W-1:0]       header,
  input  logic [NONCE_W-1:0]        nonce_first,
  input  logic [NONCE_W-1:0]        nonce_last,
  output logic [LANES*HEADER_W-1:0] core_data,
  output logic                      core_valid,
  input  logic [LANES-1:0]          core_hit,
  output logic [NONCE_W-1:0]        found_nonce,
  output logic                      found_valid,
  input  logic                      found_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow
`ifdef ODO_SCAN_STATS_EN
  ,
  output logic [47:0]               hash_count
`endif
);

  localparam int DCW = $clog2(PIPE_DEPTH + 1);

  scan_state_e               state_q, state_d;
  logic [HEADER_W-1:0]       header_q, header_d;
  logic [NONCE_W-1:0]        last_q, last_d, base_q, base_d;
  logic [DCW-1:0]            drain_cnt_q, drain_cnt_d;
  logic                      overflow_q, overflow_d;
  logic                      core_valid_q, core_valid_d;
  logic [LANES*HEADER_W-1:0] core_data_q, core_data_d;
  logic [NONCE_W-1:0]        beat_base_q, beat_base_d;
  logic [LANES-1:0]          beat_mask_q, beat_mask_d;
  logic                      dly_valid_q [PIPE_DEPTH];
  logic                      dly_valid_d [PIPE_DEPTH];
  logic [NONCE_W-1:0]        dly_base_q  [PIPE_DEPTH];
  logic [NONCE_W-1:0]        dly_base_d  [PIPE_DEPTH];
  logic [LANES-1:0]          dly_mask_q  [PIPE_DEPTH];
  logic [LANES-1:0]          dly_mask_d  [PIPE_DEPTH];

  logic [LANES-1:0]   lane_mask, hit_qual;
  logic               last_lane_reached, beat_issue;
  logic               hit_push, hit_multi, fifo_drop;
  logic [NONCE_W-1:0] hit_nonce;

  // Lane activity is decided in 33 bits so a range ending at 0xFFFFFFFF never wraps.
  always_comb begin
    for (int k = 0; k < LANES; k++)
      lane_mask[k] = ({1'b0, base_q} + 33'(k)) <= {1'b0, last_q};
    last_lane_reached = ({1'b0, base_q} + 33'(LANES - 1)) >= {1'b0, last_q};
  end

  always_comb begin
    state_d      = state_q;
    header_d     = header_q;
    last_d       = last_q;
    base_d       = base_q;
    drain_cnt_d  = drain_cnt_q;
    overflow_d   = overflow_q;
    core_valid_d = 1'b0;
    core_data_d  = core_data_q;
    beat_base_d  = beat_base_q;
    beat_mask_d  = beat_mask_q;
    beat_issue   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          header_d   = header;
          last_d     = nonce_last;
          base_d     = nonce_first;
          overflow_d = 1'b0;
          state_d    = (nonce_last < nonce_first) ? ST_DONE : ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (abort) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = DCW'(PIPE_DEPTH - 1);
        end else begin
          beat_issue   = 1'b1;
          core_valid_d = 1'b1;
          for (int k = 0; k < LANES; k++) begin
            core_data_d[k*HEADER_W +: HEADER_W]          = header_q;
            core_data_d[k*HEADER_W + NONCE_LSB +: NONCE_W] = base_q + NONCE_W'(k);
          end
          beat_base_d = base_q;
          beat_mask_d = lane_mask;
          base_d      = base_q + NONCE_W'(LANES);
          if (last_lane_reached) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DCW'(PIPE_DEPTH - 1);
          end
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == '0) state_d = ST_DONE;
        else drain_cnt_d = drain_cnt_q - DCW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    overflow_d = overflow_d | hit_multi | fifo_drop;
  end

  // The tag line's last stage lines up with the hits the core returns this cycle.
  always_comb begin
    dly_valid_d[0] = core_valid_q;
    dly_base_d[0]  = beat_base_q;
    dly_mask_d[0]  = beat_mask_q;
    for (int i = 1; i < PIPE_DEPTH; i++) begin
      dly_valid_d[i] = dly_valid_q[i-1];
      dly_base_d[i]  = dly_base_q[i-1];
      dly_mask_d[i]  = dly_mask_q[i-1];
    end
    hit_qual  = core_hit & dly_mask_q[PIPE_DEPTH-1] & {LANES{dly_valid_q[PIPE_DEPTH-1]}};
    hit_push  = |hit_qual;
    hit_multi = |(hit_qual & (hit_qual - LANES'(1)));
    hit_nonce = dly_base_q[PIPE_DEPTH-1];
    for (int k = LANES - 1; k >= 0; k--)
      if (hit_qual[k]) hit_nonce = dly_base_q[PIPE_DEPTH-1] + NONCE_W'(k);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      header_q     <= '0;
      last_q       <= '0;
      base_q       <= '0;
      drain_cnt_q  <= '0;
      overflow_q   <= 1'b0;
      core_valid_q <= 1'b0;
      core_data_q  <= '0;
      beat_base_q  <= '0;
      beat_mask_q  <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        dly_valid_q[i] <= 1'b0;
        dly_base_q[i]  <= '0;
        dly_mask_q[i]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      header_q     <= header_d;
      last_q       <= last_d;
      base_q       <= base_d;
      drain_cnt_q  <= drain_cnt_d;
      overflow_q   <= overflow_d;
      core_valid_q <= core_valid_d;
      core_data_q  <= core_data_d;
      beat_base_q  <= beat_base_d;
      beat_mask_q  <= beat_mask_d;
      dly_valid_q  <= dly_valid_d;
      dly_base_q   <= dly_base_d;
      dly_mask_q   <= dly_mask_d;
    end
  end

  odo_nonce_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (NONCE_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (hit_push),
    .push_data  (hit_nonce),
    .pop        (found_ready),
    .head       (found_nonce),
    .not_empty  (found_valid),
    .drop       (fifo_drop)
  );

`ifdef ODO_SCAN_STATS_EN
  logic [47:0] hash_count_q, hash_count_d;
  logic [48:0] hash_sum;

  always_comb begin
    hash_sum     = {1'b0, hash_count_q} + 49'(popcount8(8'(lane_mask)));
    hash_count_d = hash_count_q;
    if (beat_issue) hash_count_d = hash_sum[48] ? '1 : hash_sum[47:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hash_count_q <= '0;
    else        hash_count_q <= hash_count_d;
  end

  assign hash_count = hash_count_q;
`endif

  assign core_valid = core_valid_q;
  assign core_data  = core_data_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_odo_keccak_scan.sv
// Directed bench for odo_keccak_scan: a hash-core responder returns planned
// hits exactly PIPE_DEPTH cycles after each beat; checks are immediate asserts.
module tb_odo_keccak_scan;

  localparam int LN = 4;
  localparam int PD = 8;
  localparam int FD = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [639:0]      header = '0;
  logic [31:0]       nonce_first = '0;
  logic [31:0]       nonce_last = '0;
  logic [LN*640-1:0] core_data;
  logic              core_valid;
  logic [LN-1:0]     core_hit = '0;
  logic [31:0]       found_nonce;
  logic              found_valid;
  logic              found_ready = 1'b0;
  logic              busy, done, overflow;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [639:0]  cur_hdr = '0;
  logic [LN-1:0] stray_hit = '0;
  logic [LN-1:0] hit_plan [256];
  logic [LN-1:0] hit_pipe [PD] = '{default: '0};
  logic [31:0]   lane_log [$];
  int            beat_no = 0;
  int            last_beat_cyc = 0;
  int            hdr_bad = 0;

  odo_keccak_scan #(.LANES(LN), .PIPE_DEPTH(PD), .FIFO_DEPTH(FD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .header      (header),
    .nonce_first (nonce_first),
    .nonce_last  (nonce_last),
    .core_data   (core_data),
    .core_valid  (core_valid),
    .core_hit    (core_hit),
    .found_nonce (found_nonce),
    .found_valid (found_valid),
    .found_ready (found_ready),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Hash-core stand-in: hit answer for beat n is presented PD cycles after its core_valid.
  always @(negedge clk) begin
    core_hit = hit_pipe[PD-1] | stray_hit;
    for (int i = PD - 1; i > 0; i--) hit_pipe[i] = hit_pipe[i-1];
    hit_pipe[0] = '0;
    if (core_valid === 1'b1) begin
      hit_pipe[0] = (beat_no < 256) ? hit_plan[beat_no] : '0;
      for (int k = 0; k < LN; k++) begin
        lane_log.push_back(core_data[k*640+608 +: 32]);
        if (core_data[k*640 +: 608] !== cur_hdr[607:0]) hdr_bad++;
      end
      last_beat_cyc = cyc;
      beat_no++;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic stepCycle(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] first, input logic [31:0] last);
    header      = cur_hdr;
    nonce_first = first;
    nonce_last  = last;
    start       = 1'b1;
    stepCycle();
    start       = 1'b0;
  endtask

  task automatic waitDone(output int dcyc, output bit ok);
    ok = 1'b0;
    dcyc = 0;
    for (int i = 0; i < 300; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        dcyc = cyc;
        break;
      end
      stepCycle();
    end
  endtask

  initial begin
    int  dcyc, log0, beats0, abort_cyc;
    bit  ok;
    for (int i = 0; i < 256; i++) hit_plan[i] = '0;
    cur_hdr = {20{32'h5A3C_9E17}};

    // Reset values
    stepCycle(3);
    checkOutput("rst_core_valid", 64'(core_valid), 64'd0);
    checkOutput("rst_found_valid", 64'(found_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);
    checkOutput("rst_core_data", 64'(core_data == '0), 64'd1);
    rst_n = 1'b1;

    // Stray hits with an empty tag line must be ignored
    stray_hit = 4'hF;
    stepCycle(3);
    stray_hit = '0;
    stepCycle();
    checkOutput("stray_hit_ignored", 64'(found_valid), 64'd0);

    // Job A: 0x10..0x1F, no hits (beats 0..3)
    log0 = lane_log.size();
    applyStimulus(32'h10, 32'h1F);
    checkOutput("scan_busy", 64'(busy), 64'd1);
    waitDone(dcyc, ok);
    checkOutput("jobA_done_reached", 64'(ok), 64'd1);
    checkOutput("jobA_done_latency", 64'(dcyc - last_beat_cyc), 64'(PD));
    checkOutput("jobA_lane_count", 64'(lane_log.size() - log0), 64'd16);
    for (int i = 0; i < 16; i++)
      if (log0 + i < lane_log.size())
        checkOutput($sformatf("jobA_lane_nonce_%0d", i), 64'(lane_log[log0+i]), 64'(32'h10 + i));
    checkOutput("jobA_hdr_bits", 64'(hdr_bad), 64'd0);
    checkOutput("jobA_busy_after", 64'(busy), 64'd0);
    stepCycle(2);
    checkOutput("jobA_no_found", 64'(found_valid), 64'd0);

    // Job B: same range, lane 2 hit on second beat (global beat 5)
    hit_plan[5] = 4'b0100;
    applyStimulus(32'h10, 32'h1F);
    waitDone(dcyc, ok);
    checkOutput("jobB_done_reached", 64'(ok), 64'd1);
    stepCycle(2);
    checkOutput("jobB_found_valid", 64'(found_valid), 64'd1);
    checkOutput("jobB_found_nonce", 64'(found_nonce), 64'h16);
    checkOutput("jobB_overflow", 64'(overflow), 64'd0);

    // Job C: top-of-range, lanes 2/3 inactive, their hits ignored (beat 8)
    hit_plan[8] = 4'b1100;
    beats0 = beat_no;
    applyStimulus(32'hFFFF_FFFE, 32'hFFFF_FFFF);
    waitDone(dcyc, ok);
    checkOutput("jobC_done_reached", 64'(ok), 64'd1);
    stepCycle(2);
    checkOutput("jobC_beats", 64'(beat_no - beats0), 64'd1);
    checkOutput("jobC_lane0", 64'(lane_log[lane_log.size()-4]), 64'hFFFF_FFFE);
    checkOutput("jobC_fifo_head_kept", 64'(found_nonce), 64'h16);
    checkOutput("jobC_overflow", 64'(overflow), 64'd0);
    found_ready = 1'b1;
    stepCycle();
    found_ready = 1'b0;
    checkOutput("jobC_popped_empty", 64'(found_valid), 64'd0);

    // Job D: three single hits, FIFO of two, consumer stalled (beats 9..12)
    hit_plan[9]  = 4'b0001;
    hit_plan[10] = 4'b0010;
    hit_plan[11] = 4'b0100;
    applyStimulus(32'h100, 32'h10F);
    waitDone(dcyc, ok);
    checkOutput("jobD_done_reached", 64'(ok), 64'd1);
    stepCycle(2);
    checkOutput("jobD_overflow", 64'(overflow), 64'd1);
    checkOutput("jobD_head0", 64'(found_nonce), 64'h100);
    found_ready = 1'b1;
    stepCycle();
    checkOutput("jobD_head1_valid", 64'(found_valid), 64'd1);
    checkOutput("jobD_head1", 64'(found_nonce), 64'h105);
    stepCycle();
    found_ready = 1'b0;
    checkOutput("jobD_drained", 64'(found_valid), 64'd0);

    // Job E: start clears overflow; two simultaneous hits keep the lower one (beat 13)
    hit_plan[13] = 4'b0110;
    applyStimulus(32'h200, 32'h203);
    checkOutput("jobE_overflow_cleared", 64'(overflow), 64'd0);
    waitDone(dcyc, ok);
    checkOutput("jobE_done_reached", 64'(ok), 64'd1);
    stepCycle(2);
    checkOutput("jobE_found_nonce", 64'(found_nonce), 64'h201);
    checkOutput("jobE_overflow", 64'(overflow), 64'd1);
    found_ready = 1'b1;
    stepCycle();
    found_ready = 1'b0;
    checkOutput("jobE_popped", 64'(found_valid), 64'd0);

    // Job F: abort on the second SCAN cycle (beat 14 only)
    hit_plan[14] = 4'b1000;
    beats0 = beat_no;
    applyStimulus(32'h300, 32'h3FF);
    stepCycle();
    checkOutput("jobF_first_beat", 64'(core_valid), 64'd1);
    abort = 1'b1;
    abort_cyc = cyc;
    stepCycle();
    abort = 1'b0;
    checkOutput("jobF_valid_low", 64'(core_valid), 64'd0);
    checkOutput("jobF_busy_drain", 64'(busy), 64'd1);
    waitDone(dcyc, ok);
    checkOutput("jobF_done_reached", 64'(ok), 64'd1);
    checkOutput("jobF_done_latency", 64'(dcyc - abort_cyc), 64'(PD + 1));
    stepCycle(2);
    checkOutput("jobF_beats", 64'(beat_no - beats0), 64'd1);
    checkOutput("jobF_found_nonce", 64'(found_nonce), 64'h303);
    found_ready = 1'b1;
    stepCycle();
    found_ready = 1'b0;

    // Job G: reset mid-scan with FIFO occupied and hits still in flight
    for (int i = 15; i < 60; i++) hit_plan[i] = 4'b0001;
    applyStimulus(32'h400, 32'h4FF);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (found_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      stepCycle();
    end
    checkOutput("jobG_fifo_filled", 64'(ok), 64'd1);
    checkOutput("jobG_still_scanning", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("jobG_rst_core_valid", 64'(core_valid), 64'd0);
    checkOutput("jobG_rst_found_valid", 64'(found_valid), 64'd0);
    checkOutput("jobG_rst_busy", 64'(busy), 64'd0);
    checkOutput("jobG_rst_overflow", 64'(overflow), 64'd0);
    checkOutput("jobG_rst_core_data", 64'(core_data == '0), 64'd1);
    stepCycle(2);
    rst_n = 1'b1;
    stepCycle(PD + 4);
    checkOutput("jobG_no_late_push", 64'(found_valid), 64'd0);
    checkOutput("jobG_idle", 64'(busy | done | core_valid), 64'd0);

    // Job H: empty range goes straight to DONE without a beat
    beats0 = beat_no;
    applyStimulus(32'd5, 32'd4);
    checkOutput("jobH_done", 64'(done), 64'd1);
    checkOutput("jobH_busy", 64'(busy), 64'd0);
    stepCycle(3);
    checkOutput("jobH_no_beats", 64'(beat_no - beats0), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/odo_keccak_scan.md
ODO_KECCAK_SCAN -- requirements
Module: odo_keccak_scan

Interface
REQ-001 SHALL have parameter LANES, 4, nonce lanes issued per beat (1..8).
REQ-002 SHALL have parameter PIPE_DEPTH, 8, fixed hit latency of the external hash core, in cycles (>=1).
REQ-003 SHALL have parameter FIFO_DEPTH, 4, found-nonce FIFO entries (power of 2).
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  job start pulse.
REQ-007 SHALL have port abort  in  1  stop issuing nonces.
REQ-008 SHALL have port header  in  640  block header; bits [639:608] are the nonce field.
REQ-009 SHALL have port nonce_first  in  32  first nonce, inclusive.
REQ-010 SHALL have port nonce_last  in  32  last nonce, inclusive.
REQ-011 SHALL have port core_data  out  LANES*640  lane k header at [k*640 +: 640].
REQ-012 SHALL have port core_valid  out  1  core_data beat valid.
REQ-013 SHALL have port core_hit  in  LANES  per-lane target-met flag.
REQ-014 SHALL have port found_nonce  out  32  FIFO head nonce.
REQ-015 SHALL have port found_valid  out  1  FIFO non-empty.
REQ-016 SHALL have port found_ready  in  1  consumer pop.
REQ-017 SHALL have port busy  out  1  state SCAN or DRAIN.
REQ-018 SHALL have port done  out  1  state DONE.
REQ-019 SHALL have port overflow  out  1  sticky hit-loss flag.

Function
REQ-020 SHALL implement states IDLE, SCAN, DRAIN, DONE.
REQ-021 SHALL, on start in IDLE or DONE: latch header, nonce_first, nonce_last; base<=nonce_first; clear overflow; enter SCAN, or enter DONE next cycle without any beat if nonce_last<nonce_first; start ignored in SCAN/DRAIN.
REQ-022 SHALL, per SCAN cycle, register one beat: core_valid=1, lane k nonce field=base+k, other header bits unchanged; base+=LANES.
REQ-023 SHALL mark lane k active only if base+k<=nonce_last, compared in 33 bits (no wrap at 0xFFFFFFFF).
REQ-024 SHALL enter DRAIN after the beat whose last lane reaches or passes nonce_last.
REQ-025 SHALL hold core_valid=0 outside SCAN-issued beats.
REQ-026 SHALL track each beat's {valid, base, lane mask} in a PIPE_DEPTH-stage tag delay line; core_hit belongs to the beat whose core_valid was high exactly PIPE_DEPTH cycles earlier.
REQ-027 SHALL ignore core_hit bits of inactive lanes and of cycles with no matching beat.
REQ-028 SHALL push the lowest-index qualified hit nonce to the FIFO; further simultaneous qualified hits SHALL be dropped and set overflow.
REQ-029 SHALL, on push to a full FIFO without simultaneous pop, drop the nonce and set overflow; push and pop in the same cycle when full both succeed.
REQ-030 SHALL pop the FIFO when found_valid and found_ready are both high; found_nonce stable while found_valid and not popped.
REQ-031 SHALL leave DRAIN for DONE after PIPE_DEPTH cycles, so every issued beat's hits are collected.
REQ-032 SHALL, on abort in SCAN, issue no further beats and enter DRAIN next cycle; abort ignored in other states.
REQ-033 SHALL retain FIFO contents across jobs; only reset empties it.

Reset
REQ-034 SHALL, on rst_n low: state IDLE; core_valid, found_valid, busy, done, overflow 0; core_data 0; FIFO emptied; tag line cleared; mid-job in-flight results discarded.

Configuration
REQ-035 SHALL, with ODO_SCAN_STATS_EN defined, add output hash_count (48 bits) counting active lanes issued since reset, saturating at all-ones, unaffected by start; without it the port and counter SHALL be absent.

Structure
REQ-036 SHALL take state encoding, NONCE_MSB/NONCE_LSB (639/608) and HEADER_W (640) from package odo_pkg.
REQ-037 SHALL implement the found-nonce FIFO as sub-module odo_nonce_fifo.

Verification
REQ-038 LANES=4, PIPE_DEPTH=8, nonces 0x10..0x1F, no hits -> 4 beats, lane nonces 0x10..0x1F in order, done 8 cycles after last beat.
REQ-039 Same job, core_hit=4'b0100 for beat 2 -> found_nonce=0x16, found_valid=1.
REQ-040 nonce_first=0xFFFFFFFE, nonce_last=0xFFFFFFFF -> one beat, lanes 2,3 inactive, hit on lane 3 ignored, done reached.
REQ-041 FIFO_DEPTH=2, found_ready=0, 3 hits on separate beats -> 2 entries, overflow=1; pop yields first two nonces in order.
REQ-042 abort on second SCAN cycle -> core_valid low from third cycle, hit for beat 1 still captured, done PIPE_DEPTH cycles later.
REQ-043 rst_n low during SCAN with FIFO non-empty -> all outputs at reset values, FIFO empty, no late push.
